dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port; the core is the initiator.
- Accepts one load/store request at a time over a valid/ready request channel.
- Performs the access after a programmable latency, then returns data and status over a valid/ready response channel.
- Replaces the fixed single-cycle data memory when multi-cycle or stalled memory timing is modelled.

Parameters:
- DEPTH, 32, number of 32-bit words; must be a power of two, ≥2.
- ADDR_W, 32, request byte-address width.
- LATENCY, 2, cycles from the accept edge to rsp_valid high; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; asserted when reset==0, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for stores; bit i maps to byte i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load data; 0 for stores and on error.
- rsp_err  out  1  access faulted.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid && req_ready, latch write, addr, wdata and wstrb, load cnt=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. If cnt != 0, decrement cnt. If cnt == 0, perform the access on this edge, register rsp_rdata and rsp_err, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that handshake, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Latency: accept at edge E0 gives rsp_valid high after edge E0+LATENCY. With LATENCY=1, rsp_valid is high in the cycle immediately after the accept cycle.
- Only one outstanding request. No accept in the same cycle as the response handshake; req_ready rises the cycle after.
- Requests arriving while not in IDLE are ignored; the initiator must hold req_valid and its payload until accepted.
- Index and decode:
  - Word index = req_addr[2+log2(DEPTH)-1:2].
  - Misaligned access (addr[1:0] != 0) sets rsp_err=1, makes no memory change and returns rsp_rdata=0.
- Store merge:
  - Each byte i is replaced only when wstrb[i]=1.
  - wstrb=4'b0000 is a legal no-op store with rsp_err=0.
- Load returns the full word; byte and halfword extraction is done by the initiator.
- Reset values (reset==0 at an edge):
  - state=IDLE, cnt=0, all memory words 0.
  - req_ready=1 from the first cycle after reset is released.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Reset mid-operation: the in-flight transaction is dropped with no write performed, even if reset lands on the WAIT→RESP edge. Reset has priority over every other event.
- rsp_ready held high while not in RESP has no effect.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined: if addr[ADDR_W-1:2] >= DEPTH, rsp_err=1, no memory access, rsp_rdata=0. Timing is unchanged (still LATENCY cycles).
- Undefined: upper address bits are ignored and the index wraps modulo DEPTH. rsp_err reflects misalignment only.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP}.
  - WORD_W=32, STRB_W=4, CNT_W=4.
  - Function merging a word with byte enables.
- One natural sub-module: dmem_byte_merge (combinational; inputs old word, wdata, wstrb; output merged word). It is instantiated once and unit-testable on its own.

Test Plan:
1. Store then load, LATENCY=2:
   - Store addr 0x8, wdata 0xDEADBEEF, wstrb 4'hF; accepted at E0.
   - Required: rsp_valid high after E2, rsp_err=0, rsp_rdata=0.
   - Load addr 0x8: rsp_rdata=0xDEADBEEF.
2. Partial strobe:
   - Word 0x4 holds 0x11223344; store wdata 0xAABBCCDD with wstrb 4'b0101.
   - Required: load of 0x4 returns 0x11BB33DD.
3. Backpressure:
   - Hold rsp_ready=0 for 5 cycles after rsp_valid.
   - Required: rsp_valid, rsp_rdata and rsp_err stable throughout; req_ready=0 throughout.
   - rsp_ready=1 returns to IDLE; req_ready=1 on the next cycle.
4. Misaligned load:
   - Load addr 0x6.
   - Required: rsp_err=1, rsp_rdata=0; memory unchanged.
5. Out of range, DEPTH=32, addr 0x84:
   - With DMEM_RANGE_CHECK_EN: rsp_err=1, and word 1 is not written by the store.
   - Without: the access hits word 1 and rsp_err=0.
6. Reset mid-WAIT:
   - Store to 0x0 with LATENCY=3; reset==0 one cycle after accept.
   - Required: rsp_valid never asserts for that store; word 0 reads 0 after reset; busy=0 and req_ready=1 after reset is released.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and byte-merge helper for dmem_responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] m;
    m = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        m[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: replaces each byte of a word whose strobe bit is set.
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] merged
);

  assign merged = merge_bytes(old_word, wdata, wstrb);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable latency.
// Optional upper-address range check enabled by DMEM_RANGE_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_W  = ADDR_W - 2;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] old_word;
  logic [WORD_W-1:0] merged;
  logic              misal;
  logic              oor;
  logic              fault;
  logic              accept;
  logic              fire;
  logic              done;

  assign idx      = addr_q[IDX_W+1:2];
  assign old_word = mem[idx];
  assign misal    = |addr_q[1:0];
  assign oor      = RANGE_CHK &&
                    (addr_q[ADDR_W-1:2] >= HI_W'(DEPTH));
  assign fault    = misal | oor;

  assign accept = (state == IDLE) && req_valid;
  assign fire   = (state == WAIT) && (cnt == '0);
  assign done   = (state == RESP) && rsp_ready;

  dmem_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .wstrb    (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(LATENCY - 1);
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (fire) begin
        rsp_err   <= fault;
        rsp_rdata <= (write_q || fault) ? '0 : old_word;
      end else if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Faulted accesses never touch the array; reset beats a pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fire && write_q && !fault) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on a LATENCY=2 and a LATENCY=3 responder.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;
  logic [1:0]  busy;

  int passed;
  int total;

  dmem_responder #(.DEPTH(32), .ADDR_W(32), .LATENCY(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_write (req_write[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_wstrb (req_wstrb[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0]),
    .busy      (busy[0])
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(32), .LATENCY(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_write (req_write[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_wstrb (req_wstrb[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1]),
    .busy      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int hold, input logic [31:0] er,
                      input logic ee, input string tag);
    int n;
    int lat;
    lat = (k == 0) ? 2 : 3;
    chk({tag, ".req_ready"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_wstrb[k] = s;
    step();
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    if (!rsp_valid[k]) return;
    chk({tag, ".rdata"}, rsp_rdata[k], er);
    chk({tag, ".err"}, 32'(rsp_err[k]), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(rsp_valid[k]), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata[k], er);
      chk({tag, ".hold_err"}, 32'(rsp_err[k]), 32'(ee));
      chk({tag, ".hold_rdy"}, 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    step();
    rsp_ready[k] = 1'b0;
    chk({tag, ".post_valid"}, 32'(rsp_valid[k]), 32'd0);
    chk({tag, ".post_rdy"}, 32'(req_ready[k]), 32'd1);
    chk({tag, ".post_rdata"}, rsp_rdata[k], 32'd0);
    chk({tag, ".post_busy"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_wstrb[k] = '0;
    end
    repeat (3) step();
    reset = 1'b1;
    step();

    chk("rst.req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst.rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("rst.busy", 32'(busy[0]), 32'd0);

    rsp_ready[0] = 1'b1;
    step();
    step();
    rsp_ready[0] = 1'b0;
    chk("idle_rr.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("idle_rr.req_ready", 32'(req_ready[0]), 32'd1);

    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0, 1'b0, "ld_reset");
    xact(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "st8");
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "ld8");

    xact(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 0, 32'h0, 1'b0, "st4");
    xact(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1'b0, "st4p");
    xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h11BB33DD, 1'b0, "ld4p");

    xact(0, 1'b1, 32'h8, 32'h01020304, 4'h0, 0, 32'h0, 1'b0, "st8_nostrb");
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "ld8_nostrb");

    xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 5, 32'h11BB33DD, 1'b0, "bp_ld4");

    xact(0, 1'b0, 32'h6, 32'h0, 4'h0, 0, 32'h0, 1'b1, "ld_mis6");
    xact(0, 1'b1, 32'hA, 32'h55555555, 4'hF, 0, 32'h0, 1'b1, "st_misA");
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "ld8_mis");

`ifdef DMEM_RANGE_CHECK_EN
    xact(0, 1'b1, 32'h84, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b1, "st_oor");
    xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h11BB33DD, 1'b0, "ld4_oor");
    xact(0, 1'b0, 32'h84, 32'h0, 4'h0, 0, 32'h0, 1'b1, "ld_oor");
`else
    xact(0, 1'b1, 32'h84, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, "st_wrap");
    xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, "ld4_wrap");
    xact(0, 1'b0, 32'h84, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, "ld_wrap");
`endif

    xact(1, 1'b1, 32'h0, 32'h12345678, 4'hF, 0, 32'h0, 1'b0, "l3_st0");
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, "l3_ld0");

    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h0;
    req_wdata[1] = 32'hA5A5A5A5;
    req_wstrb[1] = 4'hF;
    step();
    req_valid[1] = 1'b0;
    chk("mid.busy_wait", 32'(busy[1]), 32'd1);
    reset = 1'b0;
    step();
    chk("mid.rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("mid.rst_busy", 32'(busy[1]), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid.rel_valid", 32'(rsp_valid[1]), 32'd0);
      chk("mid.rel_busy", 32'(busy[1]), 32'd0);
      chk("mid.rel_ready", 32'(req_ready[1]), 32'd1);
    end
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0, "mid.ld0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
